// File: rtl/linear_interpolator.sv
// -----------------------------------------------------------------------------
// linear_interpolator
//
// Upsampling stream stage. Accepts one signed sample per input handshake and,
// once two samples are known, emits FACTOR samples that walk linearly from the
// older sample (prev) toward the newer one (cur). The newer sample itself is
// emitted as the first sample of the following burst.
//
// Parameters
//   WIDTH   sample width (signed two's complement)
//   FACTOR  upsampling ratio, power of two, >= 1
//
// Ports
//   clk        clock, rising edge
//   reset      synchronous, active-low
//   in_data    signed input sample
//   in_valid   in_data valid
//   in_ready   block can accept in_data this cycle (low during a burst)
//   zoh        (only with INTERP_ZOH_EN) zero-order-hold select, sampled with
//              in_data when a burst starts; 1 = every sample of the burst is prev
//   out_data   registered interpolated sample
//   out_valid  registered out_data valid
//   out_ready  consumer accepts out_data this cycle
//
// Configuration macro
//   INTERP_ZOH_EN  adds the zoh port and the zero-order-hold mode.
// -----------------------------------------------------------------------------
module linear_interpolator #(
    parameter int WIDTH  = 8,
    parameter int FACTOR = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
`ifdef INTERP_ZOH_EN
    input  logic                    zoh,
`endif
    output logic signed [WIDTH-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int K_W = (FACTOR > 1) ? $clog2(FACTOR) : 1;
    localparam int SH  = $clog2(FACTOR);
    localparam int PW  = WIDTH + 1 + K_W;
    localparam logic [K_W-1:0] K_LAST = K_W'(FACTOR - 1);

    typedef enum logic [1:0] {
        S_PRIME = 2'd0,
        S_WAIT  = 2'd1,
        S_EMIT  = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic signed [WIDTH-1:0] r_prev;
    logic signed [WIDTH-1:0] r_cur;
    logic [K_W-1:0]          r_k;
    logic signed [WIDTH-1:0] r_out_data;
    logic                    r_out_valid;
    logic                    r_zoh;
    logic                    w_in_fire;
    logic                    w_out_fire;
    logic signed [WIDTH-1:0] w_next_sample;

    // prev + floor((cur - prev) * k / FACTOR). The difference needs one extra
    // bit, the product K_W more; the arithmetic shift floors toward -inf. The
    // result always lies between prev and cur, so truncation to WIDTH is exact.
    function automatic logic signed [WIDTH-1:0] interp(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b,
        input logic [K_W-1:0]          k
    );
        logic signed [WIDTH:0]  diff;
        logic signed [PW-1:0]   diff_x;
        logic signed [PW-1:0]   k_x;
        logic signed [PW-1:0]   prod;
        logic signed [PW-1:0]   step;
        diff   = $signed({b[WIDTH-1], b}) - $signed({a[WIDTH-1], a});
        diff_x = $signed({{(PW-WIDTH-1){diff[WIDTH]}}, diff});
        k_x    = $signed({{(PW-K_W){1'b0}}, k});
        prod   = diff_x * k_x;
        step   = prod >>> SH;
        return a + step[WIDTH-1:0];
    endfunction

    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = r_out_valid && out_ready;
    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;

    // Next sample of the running burst (index k+1); prev when holding.
    always_comb begin
        w_next_sample = interp(r_prev, r_cur, r_k + K_W'(1));
        if (r_zoh) begin
            w_next_sample = r_prev;
        end else begin
            w_next_sample = interp(r_prev, r_cur, r_k + K_W'(1));
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_PRIME;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: a burst ends on the handshake of its last sample.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_PRIME: begin
                if (w_in_fire) begin
                    w_state_next = S_WAIT;
                end else begin
                    w_state_next = S_PRIME;
                end
            end
            S_WAIT: begin
                if (w_in_fire) begin
                    w_state_next = S_EMIT;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_EMIT: begin
                if (w_out_fire && (r_k == K_LAST)) begin
                    w_state_next = S_WAIT;
                end else begin
                    w_state_next = S_EMIT;
                end
            end
            default: w_state_next = S_PRIME;
        endcase
    end

    // Output logic: input side is closed while a burst is in flight or in reset.
    always_comb begin
        in_ready = 1'b0;
        if (reset && (r_state != S_EMIT)) begin
            in_ready = 1'b1;
        end else begin
            in_ready = 1'b0;
        end
    end

    // Sample registers and registered output stream.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_prev      <= '0;
            r_cur       <= '0;
            r_k         <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_zoh       <= 1'b0;
        end else begin
            case (r_state)
                S_PRIME: begin
                    if (w_in_fire) begin
                        r_prev <= in_data;
                    end
                end
                S_WAIT: begin
                    if (w_in_fire) begin
                        r_cur       <= in_data;
                        r_k         <= '0;
                        // k == 0 sample is prev in both modes.
                        r_out_data  <= r_prev;
                        r_out_valid <= 1'b1;
`ifdef INTERP_ZOH_EN
                        r_zoh       <= zoh;
`else
                        r_zoh       <= 1'b0;
`endif
                    end
                end
                S_EMIT: begin
                    if (w_out_fire) begin
                        if (r_k == K_LAST) begin
                            r_out_valid <= 1'b0;
                            r_prev      <= r_cur;
                        end else begin
                            r_k        <= r_k + K_W'(1);
                            r_out_data <= w_next_sample;
                        end
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_linear_interpolator.sv
module tb_linear_interpolator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic signed [7:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic signed [7:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic signed [7:0] in_data1;
    logic              in_valid1;
    logic              in_ready1;
    logic signed [7:0] out_data1;
    logic              out_valid1;
    logic              out_ready1;
`ifdef INTERP_ZOH_EN
    logic              zoh;
    logic              zoh1;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int hs_cnt = 0;
    bit rand_rdy = 1'b0;
    logic signed [7:0] q[$];
    logic signed [7:0] q1[$];

    linear_interpolator #(.WIDTH(8), .FACTOR(4)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
`ifdef INTERP_ZOH_EN
        .zoh(zoh),
`endif
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    linear_interpolator #(.WIDTH(8), .FACTOR(1)) dut1 (
        .clk(clk), .reset(reset),
        .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
`ifdef INTERP_ZOH_EN
        .zoh(zoh1),
`endif
        .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push4(input int a, input int b, input int c, input int d);
        q.push_back(8'(a)); q.push_back(8'(b)); q.push_back(8'(c)); q.push_back(8'(d));
    endtask

    // Scoreboard monitor, FACTOR=4 instance: every valid cycle is checked
    // against the queue head (so a stalled sample must stay put); pop on handshake.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            if (q.size() == 0) begin
                check("unexpected_out", int'(out_data), 999);
            end else begin
                check("out_data", int'(out_data), int'(q[0]));
                if (out_ready) begin
                    void'(q.pop_front());
                    hs_cnt++;
                end
            end
        end
    end

    // Scoreboard monitor, FACTOR=1 instance.
    always @(negedge clk) begin
        if (reset && out_valid1) begin
            if (q1.size() == 0) begin
                check("f1_unexpected_out", int'(out_data1), 999);
            end else begin
                check("f1_out_data", int'(out_data1), int'(q1[0]));
                if (out_ready1) void'(q1.pop_front());
            end
        end
    end

    // Consumer: always ready, or a coin toss per cycle under backpressure.
    always @(posedge clk) begin
        #1;
        out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic send(input int d);
        int n = 0;
        in_data  = 8'(d);
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("send_timeout", n, n < 300 ? n : -1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 8'sd85;
    endtask

    task automatic send1(input int d);
        int n = 0;
        in_data1  = 8'(d);
        in_valid1 = 1'b1;
        @(negedge clk);
        while (!in_ready1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("send1_timeout", n, n < 300 ? n : -1);
        @(posedge clk); #1;
        in_valid1 = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drain_left"}, q.size(), 0);
        check({name, "_in_ready_after"}, int'(in_ready), 1);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        in_valid1 = 1'b0;
        @(posedge clk); #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_data", int'(out_data), 0);
        check("rst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        q.delete();
        q1.delete();
        hs_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
        in_data1 = '0; in_valid1 = 1'b0; out_ready1 = 1'b1;
`ifdef INTERP_ZOH_EN
        zoh = 1'b0; zoh1 = 1'b0;
`endif
        do_reset();

        // Test 1: 0 then 8; first sample one cycle after accept, input closed.
        push4(0, 2, 4, 6);
        send(0);
        send(8);
        @(negedge clk);
        check("t1_latency_valid", int'(out_valid), 1);
        check("t1_emit_in_ready", int'(in_ready), 0);
        drain("t1");

        // Test 2: continue with -8, then -8 again (flat).
        push4(8, 4, 0, -4);
        send(-8);
        drain("t2a");
        push4(-8, -8, -8, -8);
        send(-8);
        drain("t2b");

        // Test 3: extremes, negative slope floors toward -inf.
        do_reset();
        push4(127, 63, -1, -65);
        send(127);
        send(-128);
        drain("t3");

        // Test 4: random backpressure; in_valid pulses during EMIT ignored.
        do_reset();
        rand_rdy = 1'b1;
        push4(0, 2, 4, 6);
        send(0);
        send(8);
        in_data = 8'sd99;
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("t4_emit_in_ready", int'(in_ready), 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain("t4a");
        push4(8, 4, 0, -4);
        send(-8);
        drain("t4b");
        rand_rdy = 1'b0;
        @(posedge clk); #1;

        // Test 5: reset after the second output of a burst.
        do_reset();
        push4(0, 2, 4, 6);
        send(0);
        send(8);
        begin
            int n = 0;
            while (hs_cnt < 2 && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            check("t5_hs_count", hs_cnt, 2);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        check("t5_rst_out_valid", int'(out_valid), 0);
        check("t5_rst_in_ready", int'(in_ready), 0);
        reset = 1'b1;
        q.delete();
        push4(5, 6, 7, 8);
        send(5);
        send(9);
        drain("t5");

`ifdef INTERP_ZOH_EN
        // Test 6: zero-order hold burst, then linear burst.
        do_reset();
        zoh = 1'b1;
        send(4);
        push4(4, 4, 4, 4);
        send(20);
        zoh = 1'b0;
        drain("t6a");
        push4(20, 15, 10, 5);
        send(0);
        drain("t6b");
`endif

        // FACTOR=1 instance: 3,7,9 -> 3,7.
        q1.push_back(8'sd3);
        q1.push_back(8'sd7);
        send1(3);
        send1(7);
        send1(9);
        begin
            int n = 0;
            while ((q1.size() != 0 || out_valid1) && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
            check("f1_drain_left", q1.size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
